// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter that shares one asynchronous-FIFO write port among NUM_REQ
// valid/ready producers, holding each grant for a burst of at most MAX_BURST writes.
module afifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_active,
  output logic [CNT_WIDTH-1:0]          wr_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                 r_state;
  logic [IDW-1:0]         r_grant_id;
  logic [BCW-1:0]         r_beat_cnt;
  logic [CNT_WIDTH-1:0]   r_wr_count;
  logic                   r_grant_active;

  logic [IDW-1:0]         w_next_id;
  logic                   w_owner_valid;
  logic                   w_xfer;
  logic                   w_last_beat;

  // Round-robin search starting one past the current owner; descending loop so the nearest wins.
  always_comb begin : arb_search
    logic [IDW-1:0] v_idx;
    w_next_id = r_grant_id;
    v_idx     = r_grant_id;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx     = IDW'((int'(r_grant_id) + k) % NUM_REQ);
      w_next_id = req_valid[v_idx] ? v_idx : w_next_id;
    end
  end

  // Write-side handshake; reset blocks any write in the cycle it is asserted.
  always_comb begin
    w_owner_valid = req_valid[r_grant_id];
    w_xfer        = (r_state == S_GRANT) && w_owner_valid && !wfull && !wrst;
    w_last_beat   = (r_beat_cnt == BCW'(MAX_BURST - 1));
    winc          = w_xfer;
    req_ready     = w_xfer ? (NUM_REQ'(1) << r_grant_id) : {NUM_REQ{1'b0}};
    if (r_state == S_GRANT) begin
      wdata = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      wdata = {DATA_WIDTH{1'b0}};
    end
  end

  // IDLE/GRANT state machine with burst and write counters.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state        <= S_IDLE;
      r_grant_id     <= IDW'(NUM_REQ - 1);
      r_beat_cnt     <= {BCW{1'b0}};
      r_wr_count     <= {CNT_WIDTH{1'b0}};
      r_grant_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_grant_id     <= w_next_id;
            r_state        <= S_GRANT;
            r_beat_cnt     <= {BCW{1'b0}};
            r_grant_active <= 1'b1;
          end else begin
            r_grant_active <= 1'b0;
          end
        end
        S_GRANT: begin
          if (w_xfer) begin
            r_wr_count <= r_wr_count + CNT_WIDTH'(1);
            if (w_last_beat) begin
              r_state        <= S_IDLE;
              r_beat_cnt     <= {BCW{1'b0}};
              r_grant_active <= 1'b0;
            end else begin
              r_beat_cnt     <= r_beat_cnt + BCW'(1);
            end
          end else if (!w_owner_valid) begin
            r_state        <= S_IDLE;
            r_grant_active <= 1'b0;
          end else begin
            // wfull stall: hold the grant and the beat count indefinitely
            r_state        <= S_GRANT;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_grant_active <= 1'b0;
        end
      endcase
    end
  end

  assign grant_id     = r_grant_id;
  assign grant_active = r_grant_active;
  assign wr_count     = r_wr_count;

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Self-checking bench for afifo_wr_arbiter: cycle-level behavioural model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_afifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk;
  logic          wrst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          wfull;
  logic          winc;
  logic [DW-1:0] wdata;
  logic [1:0]    grant_id;
  logic          grant_active;
  logic [15:0]   wr_count;

  afifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(16)) dut (
    .wclk(clk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .grant_id(grant_id), .grant_active(grant_active), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the port, how many words it has written, total writes.
  bit          m_known = 0;
  bit          m_grant = 0;
  int          m_owner = N - 1;
  int          m_beats = 0;
  logic [15:0] m_count = 16'd0;

  logic [DW-1:0] q_wr[$];
  int            q_gnt[$];
  logic          prev_ga = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit          exp_x;
    bit          n_known, n_grant;
    int          n_owner, n_beats;
    logic [15:0] n_count;
    @(negedge clk);
    if (winc === 1'b1) q_wr.push_back(wdata);
    if (grant_active === 1'b1 && prev_ga !== 1'b1) q_gnt.push_back(int'(grant_id));
    prev_ga = grant_active;
    exp_x = m_grant && req_valid[m_owner] && !wfull && !wrst;
    if (m_known) begin
      check("winc", {31'd0, winc}, {31'd0, exp_x});
      check("req_ready", {28'd0, req_ready}, exp_x ? (32'd1 << m_owner) : 32'd0);
      if (exp_x || !m_grant)
        check("wdata", {24'd0, wdata}, m_grant ? {24'd0, req_data[m_owner*DW +: DW]} : 32'd0);
      check("grant_id", {30'd0, grant_id}, m_owner);
      check("grant_active", {31'd0, grant_active}, {31'd0, m_grant});
      check("wr_count", {16'd0, wr_count}, {16'd0, m_count});
    end
    n_known = m_known; n_grant = m_grant; n_owner = m_owner;
    n_beats = m_beats; n_count = m_count;
    if (wrst) begin
      n_known = 1; n_grant = 0; n_owner = N - 1; n_beats = 0; n_count = 16'd0;
    end else if (!m_grant) begin
      if (req_valid != '0) begin
        for (int k = N; k >= 1; k--)
          if (req_valid[(m_owner + k) % N]) n_owner = (m_owner + k) % N;
        n_grant = 1; n_beats = 0;
      end
    end else if (exp_x) begin
      n_count = m_count + 16'd1;
      n_beats = m_beats + 1;
      if (n_beats == MB) n_grant = 0;
    end else if (!req_valid[m_owner]) begin
      n_grant = 0;
    end
    @(posedge clk);
    #1;
    m_known = n_known; m_grant = n_grant; m_owner = n_owner;
    m_beats = n_beats; m_count = n_count;
  endtask

  task automatic do_reset(input int cycles);
    wrst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    wrst = 1'b0;
  endtask

  logic [15:0] base;
  int          exp_order[5];

  initial begin
    wrst = 1'b1; req_valid = '0; req_data = '0; wfull = 1'b0;

    // Reset and idle
    do_reset(2);
    #1;
    check("rst_winc", {31'd0, winc}, 32'd0);
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_count", {16'd0, wr_count}, 32'd0);
    check("rst_active", {31'd0, grant_active}, 32'd0);
    check("rst_gid", {30'd0, grant_id}, 32'd3);
    req_valid = 4'b0001; req_data[7:0] = 8'h11;
    step();
    check("first_gid", {30'd0, grant_id}, 32'd0);
    check("first_active", {31'd0, grant_active}, 32'd1);
    check("first_winc", {31'd0, winc}, 32'd1);
    step();
    req_valid = 4'b0000;
    step();
    check("first_count", {16'd0, wr_count}, 32'd1);
    check("first_release", {31'd0, grant_active}, 32'd0);

    // Burst limit: requester 2 alone, data A0..A7
    q_wr.delete();
    base = m_count;
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      req_data[23:16] = 8'hA0 + 8'(m_count - base);
      step();
    end
    req_valid = 4'b0000;
    check("burst_count", {16'd0, wr_count - base}, 32'd8);
    check("burst_gid", {30'd0, grant_id}, 32'd2);
    check("burst_nwr", q_wr.size(), 32'd8);
    for (int i = 0; i < q_wr.size() && i < 8; i++)
      check("burst_data", {24'd0, q_wr[i]}, 32'hA0 + i);
    step();

    // Round robin with all requesters valid
    do_reset(1);
    q_gnt.delete();
    req_valid = 4'b1111; req_data = 32'h44332211;
    for (int c = 0; c < 25; c++) step();
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_ngrants", q_gnt.size(), 32'd5);
    for (int i = 0; i < q_gnt.size() && i < 5; i++)
      check("rr_order", q_gnt[i], exp_order[i]);
    check("rr_count", {16'd0, wr_count}, 32'd20);
    req_valid = 4'b0000;
    step();

    // wfull stall of requester 1 after 2 beats
    do_reset(1);
    req_valid = 4'b0010; req_data[15:8] = 8'h5A;
    for (int c = 0; c < 3; c++) step();
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_winc", {31'd0, winc}, 32'd0);
      check("stall_ready", {28'd0, req_ready}, 32'd0);
      check("stall_held", {31'd0, grant_active}, 32'd1);
    end
    wfull = 1'b0;
    step(); step();
    check("stall_released", {31'd0, grant_active}, 32'd0);
    check("stall_count", {16'd0, wr_count}, 32'd4);
    req_valid = 4'b0000;
    step();

    // Early release of requester 3, then wrap-around search
    do_reset(1);
    req_valid = 4'b1000; req_data[31:24] = 8'h77;
    step(); step();
    req_valid = 4'b0000;
    #1;
    check("early_nowr", {31'd0, winc}, 32'd0);
    step();
    check("early_idle", {31'd0, grant_active}, 32'd0);
    check("early_count", {16'd0, wr_count}, 32'd1);
    req_valid = 4'b0011;
    step();
    check("wrap_gid", {30'd0, grant_id}, 32'd0);
    req_valid = 4'b0000;
    step(); step();

    // Reset mid-burst during a stalled grant with three beats done
    do_reset(1);
    req_valid = 4'b0100;
    for (int c = 0; c < 4; c++) step();
    wfull = 1'b1;
    step();
    wrst = 1'b1;
    #1;
    check("midrst_nowr", {31'd0, winc}, 32'd0);
    step();
    wrst = 1'b0;
    check("midrst_active", {31'd0, grant_active}, 32'd0);
    check("midrst_gid", {30'd0, grant_id}, 32'd3);
    check("midrst_count", {16'd0, wr_count}, 32'd0);
    // Reset while a write would otherwise happen
    wfull = 1'b0;
    step(); step();
    wrst = 1'b1;
    #1;
    check("rstwr_nowr", {31'd0, winc}, 32'd0);
    step();
    wrst = 1'b0;
    check("rstwr_count", {16'd0, wr_count}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      wrst      = ($urandom_range(0, 199) == 0);
      req_valid = 4'($urandom);
      wfull     = ($urandom_range(0, 3) == 0);
      req_data  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
